axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read port (AR/R channels) between two masters: M0 = instruction fetch / ICache refill, M1 = LSU data side (DCache refill and non-Pmem device reads).
- Selects one master per transaction, registers its AR request, and issues it to the slave.
- Routes every R beat back to the owner until r_last.
- Sits between the fetch/LSU cache read paths and the top-level AXI read interface.

Parameters:
AW, 64, address width (matches ar_addr in the LSU)
DW, 64, data width
RR_EN, 1, 1 = round-robin on a tie; 0 = fixed priority, M1 always wins a tie

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_ar_valid / m1_ar_valid  in  1  master read-address request
m0_ar_ready / m1_ar_ready  out  1  request accepted by the arbiter
m0_ar_addr / m1_ar_addr  in  AW  read address
m0_ar_len / m1_ar_len  in  8  burst length minus 1
m0_ar_size / m1_ar_size  in  3  beat size
m0_ar_burst / m1_ar_burst  in  2  burst type
m0_r_valid / m1_r_valid  out  1  read beat valid, owner only
m0_r_ready / m1_r_ready  in  1  master accepts beat
m0_r_data / m1_r_data  out  DW  copy of s_r_data
m0_r_resp / m1_r_resp  out  2  copy of s_r_resp
m0_r_last / m1_r_last  out  1  copy of s_r_last
s_ar_valid  out  1  slave address valid
s_ar_ready  in  1  slave address ready
s_ar_addr  out  AW  latched address
s_ar_len  out  8  latched length
s_ar_size  out  3  latched size
s_ar_burst  out  2  latched burst type
s_r_valid  in  1  slave beat valid
s_r_ready  out  1  equals the owner's r_ready in DATA, else 0
s_r_data  in  DW  beat data
s_r_resp  in  2  beat response
s_r_last  in  1  final beat
busy  out  1  state != IDLE
grant  out  1  current or last owner (0 = M0, 1 = M1)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state = IDLE.
  - s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst = 0.
  - all mX_ar_ready, mX_r_valid and s_r_ready = 0.
  - busy = 0, grant = 0.
  - last-served pointer = 0, so M1 wins the first tie.
  - An outstanding slave burst is abandoned; the system-level reset must also reset the slave.
- IDLE:
  - Winner selection:
    - Only one master valid: it wins.
    - Both valid, RR_EN = 1: the master not equal to the last-served pointer wins.
    - Both valid, RR_EN = 0: M1 wins.
  - The winner's ar_ready is asserted combinationally in the same cycle; the loser's ar_ready stays 0.
  - On the handshake: latch addr/len/size/burst into the s_ar_* registers, set grant = winner, go to ADDR.
  - No request: stay in IDLE with all ready/valid outputs 0.
- ADDR:
  - s_ar_valid = 1; the latched fields are held stable.
  - Both mX_ar_ready = 0.
  - On s_ar_valid && s_ar_ready: go to DATA.
- DATA:
  - s_r_data, s_r_resp and s_r_last are broadcast to both masters.
  - m{grant}_r_valid = s_r_valid; the other master's r_valid = 0.
  - s_r_ready = m{grant}_r_ready.
  - On s_r_valid && s_r_ready && s_r_last: set the last-served pointer = grant, go to IDLE.
  - Beats without last: stay in DATA.
  - Backpressure from the owner stalls the slave. No beat is dropped or duplicated.
- Latency:
  - mX_ar handshake at cycle T.
  - s_ar_valid rises at T+1.
  - The earliest next grant is the cycle after the last-beat handshake.
  - At most one outstanding transaction; no ID reordering.
- Requests arriving while busy are held off (ar_ready = 0). The master must keep ar_valid and its fields stable.
- A master that drops ar_valid before acceptance is legal in IDLE: no grant is issued.
- A non-OKAY s_r_resp is forwarded unchanged. The arbiter does not interpret it.
- grant holds its value after returning to IDLE until the next acceptance.

Test Plan:
- M0 alone requests addr 0x8000_0000 with len 3: m0_ar_ready = 1 in the same cycle, and s_ar_valid = 1 with addr 0x8000_0000 and len 3 the next cycle. After 4 beats (data 0x11..0x44), last on beat 4, return to IDLE. m1_r_valid stays 0 throughout.
- Both masters valid on the first cycle after reset, RR_EN = 1: M1 is granted first. With both still requesting, M0 is granted next, then M1 again (alternating).
- Same tie with RR_EN = 0 for 3 rounds, M0 continuously requesting: M1 is granted every round while M1 requests. M0 is granted only when m1_ar_valid = 0.
- Slave holds s_ar_ready = 0 for 5 cycles: s_ar_valid and s_ar_addr stay stable. A new m0_ar_valid in that window sees m0_ar_ready = 0.
- Owner drops r_ready for 3 cycles mid-burst: s_r_ready = 0 for those cycles. All beats arrive in order; beat count = len + 1.
- Assert reset during DATA after 2 of 4 beats: on the next edge all outputs are 0 and busy = 0. A fresh M0 request is accepted normally after reset is released.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-port arbiter: picks one master per transaction,
// registers its AR request toward the slave and steers R beats back to
// the owner until the final beat.
module axi_read_arbiter #(
   parameter int AW    = 64,
   parameter int DW    = 64,
   parameter int RR_EN = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          m0_ar_valid,
   output logic          m0_ar_ready,
   input  logic [AW-1:0] m0_ar_addr,
   input  logic [7:0]    m0_ar_len,
   input  logic [2:0]    m0_ar_size,
   input  logic [1:0]    m0_ar_burst,
   output logic          m0_r_valid,
   input  logic          m0_r_ready,
   output logic [DW-1:0] m0_r_data,
   output logic [1:0]    m0_r_resp,
   output logic          m0_r_last,
   input  logic          m1_ar_valid,
   output logic          m1_ar_ready,
   input  logic [AW-1:0] m1_ar_addr,
   input  logic [7:0]    m1_ar_len,
   input  logic [2:0]    m1_ar_size,
   input  logic [1:0]    m1_ar_burst,
   output logic          m1_r_valid,
   input  logic          m1_r_ready,
   output logic [DW-1:0] m1_r_data,
   output logic [1:0]    m1_r_resp,
   output logic          m1_r_last,
   output logic          s_ar_valid,
   input  logic          s_ar_ready,
   output logic [AW-1:0] s_ar_addr,
   output logic [7:0]    s_ar_len,
   output logic [2:0]    s_ar_size,
   output logic [1:0]    s_ar_burst,
   input  logic          s_r_valid,
   output logic          s_r_ready,
   input  logic [DW-1:0] s_r_data,
   input  logic [1:0]    s_r_resp,
   input  logic          s_r_last,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state, state_nxt;
   logic   win;       // master that would win if accepted this cycle
   logic   accept;    // AR handshake with a master in IDLE
   logic   done;      // final-beat handshake
   logic   last_srv;  // owner of the most recently completed burst
   logic   grant_q;

   // Winner selection: a lone requester wins; a tie goes to the master not
   // served last (round-robin) or to M1 (fixed priority).
   always_comb begin
      win = m1_ar_valid;
      if (m0_ar_valid && m1_ar_valid)
         win = (RR_EN != 0) ? ~last_srv : 1'b1;
   end

   // Next-state logic and all handshake outputs.
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      done        = 1'b0;
      m0_ar_ready = 1'b0;
      m1_ar_ready = 1'b0;
      s_ar_valid  = 1'b0;
      m0_r_valid  = 1'b0;
      m1_r_valid  = 1'b0;
      s_r_ready   = 1'b0;
      case (state)
         IDLE: begin
            // Held off while reset is active so no request is accepted.
            if (!reset && (m0_ar_valid || m1_ar_valid)) begin
               accept      = 1'b1;
               m0_ar_ready = ~win;
               m1_ar_ready = win;
               state_nxt   = ADDR;
            end
         end
         ADDR: begin
            s_ar_valid = 1'b1;
            if (s_ar_ready)
               state_nxt = DATA;
         end
         DATA: begin
            s_r_ready  = grant_q ? m1_r_ready : m0_r_ready;
            m0_r_valid = ~grant_q & s_r_valid;
            m1_r_valid = grant_q & s_r_valid;
            if (s_r_valid && s_r_ready && s_r_last) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Latched AR fields, current owner and last-served pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_ar_addr  <= '0;
         s_ar_len   <= '0;
         s_ar_size  <= '0;
         s_ar_burst <= '0;
         grant_q    <= 1'b0;
         last_srv   <= 1'b0;
      end else begin
         if (accept) begin
            s_ar_addr  <= win ? m1_ar_addr  : m0_ar_addr;
            s_ar_len   <= win ? m1_ar_len   : m0_ar_len;
            s_ar_size  <= win ? m1_ar_size  : m0_ar_size;
            s_ar_burst <= win ? m1_ar_burst : m0_ar_burst;
            grant_q    <= win;
         end
         if (done)
            last_srv <= grant_q;
      end
   end

   assign m0_r_data = s_r_data;
   assign m1_r_data = s_r_data;
   assign m0_r_resp = s_r_resp;
   assign m1_r_resp = s_r_resp;
   assign m0_r_last = s_r_last;
   assign m1_r_last = s_r_last;
   assign busy      = (state != IDLE);
   assign grant     = grant_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: instance 0 uses round-robin, instance 1 fixed
// priority. Tie-break table, directed corner sequences and a randomized run
// against a transaction-level reference model.
module tb_axi_read_arbiter;

   logic clock = 1'b0;
   logic reset;

   logic        m0_ar_valid [2], m1_ar_valid [2], m0_ar_ready [2], m1_ar_ready [2];
   logic [63:0] m0_ar_addr  [2], m1_ar_addr  [2];
   logic [7:0]  m0_ar_len   [2], m1_ar_len   [2];
   logic [2:0]  m0_ar_size  [2], m1_ar_size  [2];
   logic [1:0]  m0_ar_burst [2], m1_ar_burst [2];
   logic        m0_r_valid  [2], m1_r_valid  [2], m0_r_ready [2], m1_r_ready [2];
   logic [63:0] m0_r_data   [2], m1_r_data   [2];
   logic [1:0]  m0_r_resp   [2], m1_r_resp   [2];
   logic        m0_r_last   [2], m1_r_last   [2];
   logic        s_ar_valid  [2], s_ar_ready  [2];
   logic [63:0] s_ar_addr   [2];
   logic [7:0]  s_ar_len    [2];
   logic [2:0]  s_ar_size   [2];
   logic [1:0]  s_ar_burst  [2];
   logic        s_r_valid   [2], s_r_ready   [2], s_r_last [2];
   logic [63:0] s_r_data    [2];
   logic [1:0]  s_r_resp    [2];
   logic        busy        [2], grant       [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      axi_read_arbiter #(.AW(64), .DW(64), .RR_EN((k == 0) ? 1 : 0)) dut (
         .clock(clock), .reset(reset),
         .m0_ar_valid(m0_ar_valid[k]), .m0_ar_ready(m0_ar_ready[k]), .m0_ar_addr(m0_ar_addr[k]),
         .m0_ar_len(m0_ar_len[k]), .m0_ar_size(m0_ar_size[k]), .m0_ar_burst(m0_ar_burst[k]),
         .m0_r_valid(m0_r_valid[k]), .m0_r_ready(m0_r_ready[k]), .m0_r_data(m0_r_data[k]),
         .m0_r_resp(m0_r_resp[k]), .m0_r_last(m0_r_last[k]),
         .m1_ar_valid(m1_ar_valid[k]), .m1_ar_ready(m1_ar_ready[k]), .m1_ar_addr(m1_ar_addr[k]),
         .m1_ar_len(m1_ar_len[k]), .m1_ar_size(m1_ar_size[k]), .m1_ar_burst(m1_ar_burst[k]),
         .m1_r_valid(m1_r_valid[k]), .m1_r_ready(m1_r_ready[k]), .m1_r_data(m1_r_data[k]),
         .m1_r_resp(m1_r_resp[k]), .m1_r_last(m1_r_last[k]),
         .s_ar_valid(s_ar_valid[k]), .s_ar_ready(s_ar_ready[k]), .s_ar_addr(s_ar_addr[k]),
         .s_ar_len(s_ar_len[k]), .s_ar_size(s_ar_size[k]), .s_ar_burst(s_ar_burst[k]),
         .s_r_valid(s_r_valid[k]), .s_r_ready(s_r_ready[k]), .s_r_data(s_r_data[k]),
         .s_r_resp(s_r_resp[k]), .s_r_last(s_r_last[k]),
         .busy(busy[k]), .grant(grant[k])
      );
   end

   task automatic chkb(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive point just after the rising edge; sample point on the falling edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic set_m(input int d, input int m, input bit v, input logic [63:0] a,
                        input logic [7:0] l);
      if (m == 0) begin
         m0_ar_valid[d] = v; m0_ar_addr[d] = a; m0_ar_len[d] = l;
         m0_ar_size[d] = 3'd3; m0_ar_burst[d] = 2'd1;
      end else begin
         m1_ar_valid[d] = v; m1_ar_addr[d] = a; m1_ar_len[d] = l;
         m1_ar_size[d] = 3'd3; m1_ar_burst[d] = 2'd1;
      end
   endtask

   task automatic clear_inputs(input int d);
      set_m(d, 0, 1'b0, '0, '0);
      set_m(d, 1, 1'b0, '0, '0);
      m0_r_ready[d] = 1'b0; m1_r_ready[d] = 1'b0;
      s_ar_ready[d] = 1'b0; s_r_valid[d] = 1'b0; s_r_last[d] = 1'b0;
      s_r_data[d] = '0; s_r_resp[d] = '0;
   endtask

   task automatic do_reset();
      cyc();
      reset = 1'b1;
      clear_inputs(0);
      clear_inputs(1);
      cyc();
      reset = 1'b0;
   endtask

   task automatic chk_quiet(input string nm, input int d);
      chkb({nm, "_m0_ar_ready"}, m0_ar_ready[d], 1'b0);
      chkb({nm, "_m1_ar_ready"}, m1_ar_ready[d], 1'b0);
      chkb({nm, "_m0_r_valid"}, m0_r_valid[d], 1'b0);
      chkb({nm, "_m1_r_valid"}, m1_r_valid[d], 1'b0);
      chkb({nm, "_s_ar_valid"}, s_ar_valid[d], 1'b0);
      chkw({nm, "_s_ar_addr"}, s_ar_addr[d], 64'd0);
      chkw({nm, "_s_ar_len"}, 64'(s_ar_len[d]), 64'd0);
      chkw({nm, "_s_ar_size"}, 64'(s_ar_size[d]), 64'd0);
      chkw({nm, "_s_ar_burst"}, 64'(s_ar_burst[d]), 64'd0);
      chkb({nm, "_s_r_ready"}, s_r_ready[d], 1'b0);
      chkb({nm, "_busy"}, busy[d], 1'b0);
      chkb({nm, "_grant"}, grant[d], 1'b0);
   endtask

   // One single-beat transaction; w is the master expected to win.
   task automatic txn_quick(input int d, input bit v0, input bit v1, input int w);
      logic [63:0] a0 = 64'h1000_0000;
      logic [63:0] a1 = 64'h2000_0000;
      cyc();
      set_m(d, 0, v0, a0, 8'd0);
      set_m(d, 1, v1, a1, 8'd0);
      m0_r_ready[d] = 1'b1; m1_r_ready[d] = 1'b1;
      smp();
      chkb("q_m0_ar_ready", m0_ar_ready[d], w == 0);
      chkb("q_m1_ar_ready", m1_ar_ready[d], w == 1);
      cyc();
      m0_ar_valid[d] = 1'b0; m1_ar_valid[d] = 1'b0;
      s_ar_ready[d] = 1'b1;
      smp();
      chkb("q_s_ar_valid", s_ar_valid[d], 1'b1);
      chkw("q_s_ar_addr", s_ar_addr[d], (w == 1) ? a1 : a0);
      chkb("q_grant", grant[d], w == 1);
      chkb("q_busy", busy[d], 1'b1);
      cyc();
      s_ar_ready[d] = 1'b0;
      s_r_valid[d] = 1'b1; s_r_last[d] = 1'b1; s_r_data[d] = 64'hD0;
      smp();
      chkb("q_m0_r_valid", m0_r_valid[d], w == 0);
      chkb("q_m1_r_valid", m1_r_valid[d], w == 1);
      chkb("q_s_r_ready", s_r_ready[d], 1'b1);
      cyc();
      s_r_valid[d] = 1'b0; s_r_last[d] = 1'b0;
      smp();
      chkb("q_idle_busy", busy[d], 1'b0);
      chkb("q_grant_hold", grant[d], w == 1);
   endtask

   // Randomized traffic checked against a transaction-level model:
   // phase 0 = waiting for a request, 1 = address offered, 2 = beats flowing.
   task automatic run_random(input int d, input int ncyc);
      bit          rv [2];
      logic [63:0] ra [2];
      logic [7:0]  rl [2];
      bit          rr [2];
      bit          sar, bv, any;
      logic [63:0] bdata;
      logic [1:0]  bresp;
      logic [7:0]  bidx = '0;
      logic [63:0] lat_a = '0;
      logic [7:0]  lat_l = '0;
      int          phase = 0, owner = 0, last_s = 0, win;
      rv[0] = 0; rv[1] = 0; bv = 0; bdata = '0; bresp = '0;
      for (int c = 0; c < ncyc; c++) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            if (!rv[m] && $urandom_range(0, 2) == 0) begin
               rv[m] = 1;
               ra[m] = {$urandom, $urandom};
               rl[m] = 8'($urandom_range(0, 3));
            end
            if (rv[m]) set_m(d, m, 1'b1, ra[m], rl[m]);
            else       set_m(d, m, 1'b0, '0, '0);
            rr[m] = ($urandom_range(0, 3) != 0);
         end
         m0_r_ready[d] = rr[0]; m1_r_ready[d] = rr[1];
         sar = ($urandom_range(0, 1) == 1);
         s_ar_ready[d] = sar;
         if (phase == 2 && !bv && $urandom_range(0, 3) != 0) begin
            bv = 1; bdata = {$urandom, $urandom}; bresp = 2'($urandom_range(0, 3));
         end
         s_r_valid[d] = bv; s_r_data[d] = bdata; s_r_resp[d] = bresp;
         s_r_last[d] = bv && (bidx == lat_l);
         smp();
         any = rv[0] || rv[1];
         if (rv[0] && rv[1]) win = (d == 0) ? 1 - last_s : 1;
         else                win = rv[1] ? 1 : 0;
         chkb("r_m0_ar_ready", m0_ar_ready[d], phase == 0 && rv[0] && win == 0);
         chkb("r_m1_ar_ready", m1_ar_ready[d], phase == 0 && rv[1] && win == 1);
         chkb("r_s_ar_valid", s_ar_valid[d], phase == 1);
         chkb("r_busy", busy[d], phase != 0);
         if (phase == 1) begin
            chkw("r_s_ar_addr", s_ar_addr[d], lat_a);
            chkw("r_s_ar_len", 64'(s_ar_len[d]), 64'(lat_l));
         end
         if (phase != 0) chkb("r_grant", grant[d], owner == 1);
         chkb("r_m0_r_valid", m0_r_valid[d], phase == 2 && owner == 0 && bv);
         chkb("r_m1_r_valid", m1_r_valid[d], phase == 2 && owner == 1 && bv);
         chkb("r_s_r_ready", s_r_ready[d], phase == 2 && rr[owner]);
         if (phase == 2 && bv) begin
            chkw("r_r_data", (owner == 1) ? m1_r_data[d] : m0_r_data[d], bdata);
            chkw("r_r_resp", 64'((owner == 1) ? m1_r_resp[d] : m0_r_resp[d]), 64'(bresp));
         end
         case (phase)
            0: if (any) begin
                  owner = win; lat_a = ra[win]; lat_l = rl[win]; rv[win] = 0; phase = 1;
               end
            1: if (sar) begin phase = 2; bidx = '0; end
            default: if (bv && rr[owner]) begin
                  bv = 0;
                  if (bidx == lat_l) begin last_s = owner; phase = 0; end
                  else bidx = bidx + 8'd1;
               end
         endcase
      end
   endtask

   typedef struct {
      int d;
      bit v0, v1;
      bit e0, e1;
   } vec_t;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      int          got;
      logic [7:0]  idx;
      bit          rdy;

      tbl[0] = '{0, 0, 0, 0, 0};
      tbl[1] = '{0, 1, 0, 1, 0};
      tbl[2] = '{0, 0, 1, 0, 1};
      tbl[3] = '{0, 1, 1, 0, 1};
      tbl[4] = '{1, 1, 1, 0, 1};
      tbl[5] = '{1, 1, 0, 1, 0};
      tbl[6] = '{1, 0, 1, 0, 1};
      tbl[7] = '{1, 0, 0, 0, 0};

      reset = 1'b1;
      clear_inputs(0);
      clear_inputs(1);
      do_reset();
      smp();
      chk_quiet("rst0", 0);
      chk_quiet("rst1", 1);

      // Tie-break table from the reset state; valids drop before the edge,
      // so no request is ever accepted.
      foreach (tbl[i]) begin
         cyc();
         m0_ar_valid[tbl[i].d] = tbl[i].v0;
         m1_ar_valid[tbl[i].d] = tbl[i].v1;
         smp();
         chkb("tbl_m0_ar_ready", m0_ar_ready[tbl[i].d], tbl[i].e0);
         chkb("tbl_m1_ar_ready", m1_ar_ready[tbl[i].d], tbl[i].e1);
         #1;
         m0_ar_valid[tbl[i].d] = 1'b0;
         m1_ar_valid[tbl[i].d] = 1'b0;
      end
      smp();
      chkb("drop_busy0", busy[0], 1'b0);
      chkb("drop_busy1", busy[1], 1'b0);

      // M0 alone, four-beat burst.
      do_reset();
      cyc();
      set_m(0, 0, 1'b1, 64'h8000_0000, 8'd3);
      m0_r_ready[0] = 1'b1;
      smp();
      chkb("m0a_ar_ready", m0_ar_ready[0], 1'b1);
      chkb("m0a_m1_ar_ready", m1_ar_ready[0], 1'b0);
      cyc();
      m0_ar_valid[0] = 1'b0;
      s_ar_ready[0] = 1'b1;
      smp();
      chkb("m0a_s_ar_valid", s_ar_valid[0], 1'b1);
      chkw("m0a_s_ar_addr", s_ar_addr[0], 64'h8000_0000);
      chkw("m0a_s_ar_len", 64'(s_ar_len[0]), 64'd3);
      for (int i = 0; i < 4; i++) begin
         cyc();
         s_ar_ready[0] = 1'b0;
         s_r_valid[0] = 1'b1;
         s_r_data[0] = 64'(i + 1) * 64'h11;
         s_r_last[0] = (i == 3);
         smp();
         chkb("m0a_r_valid", m0_r_valid[0], 1'b1);
         chkb("m0a_m1_r_valid", m1_r_valid[0], 1'b0);
         chkw("m0a_r_data", m0_r_data[0], 64'(i + 1) * 64'h11);
         chkb("m0a_r_last", m0_r_last[0], i == 3);
      end
      cyc();
      s_r_valid[0] = 1'b0; s_r_last[0] = 1'b0;
      smp();
      chkb("m0a_done_busy", busy[0], 1'b0);

      // Ties: round-robin alternates starting with M1; fixed priority keeps M1.
      do_reset();
      txn_quick(0, 1, 1, 1);
      txn_quick(0, 1, 1, 0);
      txn_quick(0, 1, 1, 1);
      for (int r = 0; r < 3; r++) txn_quick(1, 1, 1, 1);
      txn_quick(1, 1, 0, 0);

      // Slave stalls AR for five cycles while M0 presents a new request.
      do_reset();
      cyc();
      set_m(0, 0, 1'b1, 64'h3000, 8'd1);
      m0_r_ready[0] = 1'b1;
      smp();
      chkb("stall_accept", m0_ar_ready[0], 1'b1);
      cyc();
      set_m(0, 0, 1'b1, 64'h4000, 8'd0);
      for (int k = 0; k < 5; k++) begin
         smp();
         chkb("stall_s_ar_valid", s_ar_valid[0], 1'b1);
         chkw("stall_s_ar_addr", s_ar_addr[0], 64'h3000);
         chkb("stall_m0_ar_ready", m0_ar_ready[0], 1'b0);
         cyc();
      end
      s_ar_ready[0] = 1'b1;
      smp();
      cyc();
      s_ar_ready[0] = 1'b0;
      s_r_valid[0] = 1'b1; s_r_last[0] = 1'b0;
      smp();
      chkb("stall_s_r_ready", s_r_ready[0], 1'b1);
      cyc();
      s_r_last[0] = 1'b1;
      smp();
      cyc();
      s_r_valid[0] = 1'b0; s_r_last[0] = 1'b0;
      smp();
      chkb("stall_next_accept", m0_ar_ready[0], 1'b1);

      // Owner backpressure mid-burst.
      do_reset();
      cyc();
      set_m(0, 0, 1'b1, 64'h5000, 8'd3);
      m0_r_ready[0] = 1'b1;
      smp();
      cyc();
      set_m(0, 0, 1'b0, '0, '0);
      s_ar_ready[0] = 1'b1;
      smp();
      got = 0;
      idx = '0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         cyc();
         s_ar_ready[0] = 1'b0;
         rdy = !(c >= 1 && c <= 3);
         m0_r_ready[0] = rdy;
         s_r_valid[0] = 1'b1;
         s_r_data[0] = 64'hA0 + 64'(idx);
         s_r_last[0] = (idx == 8'd3);
         smp();
         if (!rdy) chkb("bp_s_r_ready", s_r_ready[0], 1'b0);
         if (m0_r_valid[0] && m0_r_ready[0]) begin
            chkw("bp_data", m0_r_data[0], 64'hA0 + 64'(got));
            got++;
         end
         if (rdy) idx = idx + 8'd1;
      end
      chkw("bp_beat_count", 64'(got), 64'd4);
      cyc();
      s_r_valid[0] = 1'b0; s_r_last[0] = 1'b0;
      smp();
      chkb("bp_done_busy", busy[0], 1'b0);

      // Reset asserted in the middle of an M1 burst, then a fresh M0 request.
      do_reset();
      cyc();
      set_m(0, 1, 1'b1, 64'h6000, 8'd3);
      m1_r_ready[0] = 1'b1;
      smp();
      cyc();
      set_m(0, 1, 1'b0, '0, '0);
      s_ar_ready[0] = 1'b1;
      smp();
      for (int i = 0; i < 2; i++) begin
         cyc();
         s_ar_ready[0] = 1'b0;
         s_r_valid[0] = 1'b1;
         s_r_data[0] = 64'(i);
         smp();
      end
      cyc();
      reset = 1'b1;
      smp();
      chk_quiet("midrst", 0);
      cyc();
      reset = 1'b0;
      clear_inputs(0);
      cyc();
      set_m(0, 0, 1'b1, 64'h7000, 8'd2);
      smp();
      chkb("post_rst_accept", m0_ar_ready[0], 1'b1);
      cyc();
      set_m(0, 0, 1'b0, '0, '0);
      smp();
      chkb("post_rst_s_ar_valid", s_ar_valid[0], 1'b1);
      chkw("post_rst_s_ar_addr", s_ar_addr[0], 64'h7000);
      chkb("post_rst_grant", grant[0], 1'b0);

      // Randomized traffic on both arbitration modes.
      for (int d = 0; d < 2; d++) begin
         do_reset();
         run_random(d, 1500);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
